// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add unsigned multiplier that borrows an external shared ALU for its adds.
// Each CALC cycle performs one add, then shifts the carry, the sum and q right by one bit.
module alu_mul_seq #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product,
  output logic [W-1:0]   alu_in1,
  output logic [W-1:0]   alu_in2,
  output logic [2:0]     alu_opsel,
  input  logic [W-1:0]   alu_out,
  input  logic [3:0]     alu_status
);

  localparam int unsigned CntW = $clog2(W);
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e          r_state;
  logic [W-1:0]    r_mcand;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_acc;
  logic [CntW-1:0] r_cnt;
  logic [2*W-1:0]  r_product;

  logic           w_calc;
  logic [2*W-1:0] w_shift;
  logic           w_unused_status;

  assign w_calc = (r_state == StCalc);

  // {carry, sum, q} shifted right by one; the q LSB just consumed drops out.
  assign w_shift = {alu_status[1], alu_out, r_q[W-1:1]};

  // Only the carry flag feeds the datapath.
  assign w_unused_status = ^{alu_status[3:2], alu_status[0]};

  always_comb begin
    alu_in1   = '0;
    alu_in2   = '0;
    alu_opsel = 3'b111;
    if (w_calc) begin
      alu_in1   = r_acc;
      alu_in2   = r_q[0] ? r_mcand : '0;
      alu_opsel = 3'b000;
    end
  end

  assign busy    = w_calc;
  assign done    = (r_state == StDone);
  assign product = r_product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_mcand   <= '0;
      r_q       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_mcand <= op_a;
            r_q     <= op_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= StCalc;
          end
        end
        StCalc: begin
          r_acc <= w_shift[2*W-1:W];
          r_q   <= w_shift[W-1:0];
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == CntLast) begin
            r_product <= w_shift;
            r_state   <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq with a behavioural ALU; expected values come from plain integer arithmetic.
module tb_alu_mul_seq;

  localparam int unsigned W = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   alu_in1;
  logic [W-1:0]   alu_in2;
  logic [2:0]     alu_opsel;
  logic [W-1:0]   alu_out;
  logic [3:0]     alu_status;
  logic [W:0]     alu_sum;

  int n_tests;
  int n_fail;
  int prev_product;

  alu_mul_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_opsel (alu_opsel),
    .alu_out   (alu_out),
    .alu_status(alu_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: opsel 000 adds, anything else yields zero.
  always_comb begin
    alu_sum = '0;
    if (alu_opsel == 3'b000) alu_sum = {1'b0, alu_in1} + {1'b0, alu_in2};
  end
  assign alu_out = alu_sum[W-1:0];
  assign alu_status = {alu_out[W-1], (alu_out == '0), alu_sum[W],
                       (alu_opsel == 3'b000) && (alu_in1[W-1] == alu_in2[W-1]) &&
                       (alu_out[W-1] != alu_in1[W-1])};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_alu_idle(input string tag);
    check({tag, "_opsel"}, 32'(alu_opsel), 32'd7);
    check({tag, "_in1"}, 32'(alu_in1), 32'd0);
    check({tag, "_in2"}, 32'(alu_in2), 32'd0);
  endtask

  // Called at a negedge; returns at a negedge one cycle after DONE.
  task automatic do_mul(input int a, input int b, input bit noisy);
    longint r;
    int     exp_in2;
    start = 1'b1;
    op_a  = W'(a);
    op_b  = W'(b);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      // After i steps the {acc,q} pair equals (b + a*(b mod 2^i)*2^W) / 2^i.
      r = (longint'(b) + ((longint'(a) * longint'(b % (1 << i))) << W)) >> i;
      exp_in2 = ((b >> i) & 1) != 0 ? a : 0;
      check("calc_busy", 32'(busy), 32'd1);
      check("calc_done", 32'(done), 32'd0);
      check("calc_opsel", 32'(alu_opsel), 32'd0);
      check("calc_in1", 32'(alu_in1), 32'(r >> W));
      check("calc_in2", 32'(alu_in2), 32'(exp_in2));
      check("calc_prod_hold", 32'(product), 32'(prev_product));
      if (noisy) begin
        start = 1'($urandom);
        op_a  = W'($urandom);
        op_b  = W'($urandom);
      end
      @(negedge clk);
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_product", 32'(product), 32'(a * b));
    check_alu_idle("done");
    if (noisy) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev_product = a * b;
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_product", 32'(product), 32'(prev_product));
  endtask

  initial begin
    int done_cycles[$];
    int pairs[$];
    int j;
    int tmp;
    n_tests = 0;
    n_fail = 0;
    prev_product = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op_a = '0;
    op_b = '0;

    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check_alu_idle("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check_alu_idle("idle");

    do_mul(15, 15, 1'b0);
    do_mul(9, 11, 1'b0);
    do_mul(0, 13, 1'b0);
    do_mul(1, 0, 1'b0);
    do_mul(7, 6, 1'b1);

    // Start held high: results every W+2 cycles, nothing queued.
    start = 1'b1;
    op_a = 4'd3;
    op_b = 4'd5;
    for (int s = 1; s <= 30; s++) begin
      @(negedge clk);
      if (done) begin
        done_cycles.push_back(s);
        check("b2b_product", 32'(product), 32'd15);
      end
    end
    start = 1'b0;
    prev_product = 15;
    check("b2b_count", 32'(done_cycles.size()), 32'd5);
    for (int k = 1; k < done_cycles.size(); k++)
      check("b2b_interval", 32'(done_cycles[k] - done_cycles[k-1]), 32'(W + 2));

    // Reset in the second CALC cycle aborts without a done pulse.
    @(negedge clk);
    start = 1'b1;
    op_a = 4'd12;
    op_b = 4'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    check_alu_idle("abort");
    @(negedge clk);
    rst_n = 1'b1;
    prev_product = 0;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_no_busy", 32'(busy), 32'd0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_mul(12, 10, 1'b0);

    // Every operand pair in random order, with noise on start/operands while busy.
    for (int p = 0; p < 256; p++) pairs.push_back(p);
    for (int p = 255; p > 0; p--) begin
      j = int'($urandom_range(p, 0));
      tmp = pairs[p];
      pairs[p] = pairs[j];
      pairs[j] = tmp;
    end
    foreach (pairs[p]) do_mul(pairs[p] >> 4, pairs[p] & 15, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning operand width in bits (W >= 2).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL provide port clk  input  1  rising-edge clock.
REQ-004 The block SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL provide port start  input  1  request a multiply; sampled only in IDLE.
REQ-006 The block SHALL provide port op_a  input  W  multiplicand, unsigned; sampled with start.
REQ-007 The block SHALL provide port op_b  input  W  multiplier, unsigned; sampled with start.
REQ-008 The block SHALL provide port busy  output  1  high while the iteration is in progress.
REQ-009 The block SHALL provide port done  output  1  one-cycle pulse when product is valid.
REQ-010 The block SHALL provide port product  output  2W  registered result op_a*op_b.
REQ-011 The block SHALL provide port alu_in1  output  W  drives the shared ALU In1.
REQ-012 The block SHALL provide port alu_in2  output  W  drives the shared ALU In2.
REQ-013 The block SHALL provide port alu_opsel  output  3  drives the ALU OpSel (000 add, 111 zero).
REQ-014 The block SHALL provide port alu_out  input  W  ALU Out.
REQ-015 The block SHALL provide port alu_status  input  4  ALU Status {N,Z,CO,OVF}; only bit 1 (CO) is used.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, CALC, DONE.
REQ-017 IDLE with start=1 at a clock edge SHALL load mcand<=op_a, q<=op_b, acc<=0, cnt<=0 and go to CALC.
REQ-018 IDLE with start=0 SHALL remain in IDLE; all registers hold.
REQ-019 In CALC, combinationally: alu_in1=acc, alu_in2=(q[0] ? mcand : 0), alu_opsel=000.
REQ-020 In CALC, each edge SHALL update {acc,q} <= {alu_status[1], alu_out, q} >> 1 (2W+1-bit shift, carry into MSB of acc), and cnt<=cnt+1.
REQ-021 CALC SHALL last exactly W cycles; the edge on which cnt==W-1 SHALL move to DONE and register product<={next acc, next q}.
REQ-022 DONE SHALL last exactly one cycle, done=1, then return to IDLE unconditionally.
REQ-023 busy SHALL be 1 exactly in CALC; done SHALL be 1 exactly in DONE; both are decoded from registered state.
REQ-024 Total latency: start accepted at edge k -> done high during the cycle after edge k+W; throughput one multiply per W+2 cycles.
REQ-025 In IDLE and DONE, alu_in1=0, alu_in2=0, alu_opsel=111, so the ALU output is zero and the ALU is free for other users.
REQ-026 start asserted in CALC or DONE SHALL be ignored (no queueing); op_a/op_b changes after acceptance SHALL NOT affect the result.
REQ-027 product SHALL hold its value from DONE until the next DONE; it is not cleared by a new start.
REQ-028 Carry out of an add of zero SHALL be taken from CO as returned (0 with a correct ALU); the block SHALL NOT mask it.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, product=0, acc=0, q=0, mcand=0, cnt=0, independent of clk.
REQ-030 Reset during CALC or DONE SHALL abort the operation with no done pulse; after release the block SHALL accept start on the first edge.

Verification (W=4, ALU model connected)
REQ-031 op_a=15, op_b=15, start pulse -> busy high for 4 cycles, done one cycle later, product=0xE1 (225).
REQ-032 op_a=9, op_b=11 -> product=0x63 (99); op_a=0, op_b=13 -> product=0x00; op_a=1, op_b=0 -> product=0x00.
REQ-033 start held high continuously with op_a=3, op_b=5 -> back-to-back results every 6 cycles, product=0x0F, start ignored while busy.
REQ-034 During CALC change op_a/op_b to 0 -> result still reflects sampled operands (e.g. 7*6 -> 0x2A).
REQ-035 rst_n pulsed low in 2nd CALC cycle of 12*10 -> busy=0, done never pulses, product=0; next start 12*10 -> 0x78.
REQ-036 IDLE/DONE cycles -> alu_opsel=111, alu_in1=alu_in2=0; random sweep of all 256 operand pairs matches reference product.
